// File: rtl/cpu_ctrl_seq.sv
// rtl/cpu_ctrl_seq.sv - eight-phase instruction sequencer for the 8-bit accumulator CPU
// Optional single-step control is enabled by defining CPU_CTRL_STEP_EN.
module cpu_ctrl_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       opcode,
  input  logic             zero,
  input  logic             resume,
`ifdef CPU_CTRL_STEP_EN
  input  logic             step_mode,
  input  logic             step,
`endif
  output logic             sel,
  output logic             rd,
  output logic             ld_ir,
  output logic             inc_pc,
  output logic             ld_pc,
  output logic             ld_ac,
  output logic             wr,
  output logic             data_e,
  output logic             halt,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] instr_cnt
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_t;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  phase_t           state;
  phase_t           state_next;
  logic             halted;
  logic             halted_next;
  logic             retire;
  logic             alu_op;
  logic             start_ok;
  logic [CNT_W-1:0] cnt_q;

  // Whether the sequencer may leave INST_ADDR this cycle; in step mode it
  // parks there until a step pulse arrives.
`ifdef CPU_CTRL_STEP_EN
  assign start_ok = !step_mode || step;
`else
  assign start_ok = 1'b1;
`endif

  // Opcodes that read an operand from memory and load the accumulator.
  assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                  (opcode == OP_XOR) || (opcode == OP_LDA);

  // State, halted flag and retired-instruction counter; reset wins over all.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= INST_ADDR;
      halted <= 1'b0;
      cnt_q  <= '0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
      if (retire) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic: linear walk through the phases, with HLT diverting
  // to the halted flag from OP_ADDR.
  always_comb begin
    state_next  = state;
    halted_next = halted;
    retire      = 1'b0;
    if (halted) begin
      // Phase is parked at INST_ADDR so that resuming restarts a fetch.
      state_next = INST_ADDR;
      if (resume) begin
        halted_next = 1'b0;
      end
    end else begin
      case (state)
        INST_ADDR: begin
          if (start_ok) begin
            state_next = INST_FETCH;
          end
        end
        INST_FETCH: state_next = INST_LOAD;
        INST_LOAD:  state_next = IDLE;
        IDLE:       state_next = OP_ADDR;
        OP_ADDR: begin
          if (opcode == OP_HLT) begin
            halted_next = 1'b1;
            state_next  = INST_ADDR;
          end else begin
            state_next = OP_FETCH;
          end
        end
        OP_FETCH:   state_next = ALU_OP;
        ALU_OP:     state_next = STORE;
        STORE: begin
          state_next = INST_ADDR;
          retire     = 1'b1;
        end
        default:    state_next = INST_ADDR;
      endcase
    end
  end

  // Strobe decode from the registered phase plus live opcode/zero.
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    ld_pc  = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    data_e = 1'b0;
    halt   = 1'b0;
    if (halted) begin
      halt = 1'b1;
    end else begin
      case (state)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = (opcode == OP_HLT);
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          // The ALU captures its result on the negedge inside this phase.
          rd     = alu_op;
          inc_pc = (opcode == OP_SKZ) && zero;
          ld_pc  = (opcode == OP_JMP);
          data_e = (opcode == OP_STO);
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = (opcode == OP_JMP);
          wr     = (opcode == OP_STO);
          data_e = (opcode == OP_STO);
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign phase     = halted ? 3'd0 : state;
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// tb/tb_cpu_ctrl_seq.sv - randomized and directed bench for cpu_ctrl_seq against a phase-table model
module tb_cpu_ctrl_seq;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic [2:0]    opcode;
  logic          zero;
  logic          resume;
  logic          sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt;
  logic [2:0]    phase;
  logic [CW-1:0] instr_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: phase number, halted flag, retired count.
  int   mp = 0;
  logic mh = 1'b0;
  int   mcnt = 0;
  logic mvalid = 1'b0;

  cpu_ctrl_seq #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero      (zero),
    .resume    (resume),
`ifdef CPU_CTRL_STEP_EN
    .step_mode (1'b0),
    .step      (1'b0),
`endif
    .sel       (sel),
    .rd        (rd),
    .ld_ir     (ld_ir),
    .inc_pc    (inc_pc),
    .ld_pc     (ld_pc),
    .ld_ac     (ld_ac),
    .wr        (wr),
    .data_e    (data_e),
    .halt      (halt),
    .phase     (phase),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected strobes {sel,rd,ld_ir,inc_pc,ld_pc,ld_ac,wr,data_e,halt}.
  function automatic logic [8:0] exp_out(input int p, input logic h, input logic [2:0] op, input logic z);
    logic aluop;
    logic s, r, li, ip, lp, la, w, de, hl;
    aluop = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    s = 0; r = 0; li = 0; ip = 0; lp = 0; la = 0; w = 0; de = 0; hl = 0;
    if (h) begin
      hl = 1;
    end else begin
      s  = (p <= 3);
      r  = (p >= 1 && p <= 3) || (p >= 5 && aluop);
      li = (p == 2 || p == 3);
      ip = (p == 4) || (p == 6 && op == 3'd1 && z);
      lp = (p == 6 || p == 7) && op == 3'd7;
      la = (p == 7) && aluop;
      w  = (p == 7) && op == 3'd6;
      de = (p == 6 || p == 7) && op == 3'd6;
      hl = (p == 4) && op == 3'd0;
    end
    return {s, r, li, ip, lp, la, w, de, hl};
  endfunction

  // Model advance on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      mp <= 0; mh <= 1'b0; mcnt <= 0; mvalid <= 1'b1;
    end else if (mh) begin
      if (resume) mh <= 1'b0;
    end else if (mp == 4 && opcode == 3'd0) begin
      mh <= 1'b1; mp <= 0;
    end else if (mp == 7) begin
      mp <= 0; mcnt <= (mcnt + 1) % (1 << CW);
    end else begin
      mp <= mp + 1;
    end
  end

  // Every-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("strobes", int'({sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}),
          int'(exp_out(mp, mh, opcode, zero)));
      chk("phase", int'(phase), mh ? 0 : mp);
      chk("instr_cnt", int'(instr_cnt), mcnt);
    end
  end

  // Advance one clock, then drive inputs for the new cycle. The operand
  // opcode is held only while the model is in phases 4..7; junk otherwise.
  task automatic step(input int op, input logic z, input logic r, input logic res);
    @(posedge clk);
    #1;
    rst    = r;
    resume = res;
    zero   = z;
    if (!mh && mp >= 4) opcode = 3'(op);
    else opcode = 3'($urandom);
  endtask

  task automatic goto(input int k, input int op, input logic z);
    int n;
    n = 0;
    do begin
      step(op, z, 1'b0, 1'b0);
      n++;
    end while (!(mp == k && !mh) && n < 40);
    if (n >= 40) chk("goto_timeout", n, 0);
    @(negedge clk);
  endtask

  initial begin
    int rop;
    rst = 1'b1; opcode = 3'd0; zero = 1'b0; resume = 1'b0;
    step(2, 0, 1'b1, 1'b0);
    step(2, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("rst_phase", int'(phase), 0);
    chk("rst_sel", int'(sel), 1);
    chk("rst_strobes", int'({rd, ld_ir, inc_pc, ld_pc, ld_ac, wr, data_e, halt}), 0);
    chk("rst_cnt", int'(instr_cnt), 0);

    // ADD walk through every phase.
    for (int i = 1; i <= 7; i++) begin
      step(2, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk("seq_phase", int'(phase), i);
      if (i >= 5) chk("add_rd", int'(rd), 1);
      chk("add_ld_ac", int'(ld_ac), (i == 7) ? 1 : 0);
      chk("add_wr", int'(wr), 0);
      chk("add_ld_pc", int'(ld_pc), 0);
    end
    step(2, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("add_retire_phase", int'(phase), 0);
    chk("add_retire_cnt", int'(instr_cnt), 1);

    // SKZ with zero set and clear.
    goto(4, 1, 1'b1); chk("skz_p4", int'(inc_pc), 1);
    goto(6, 1, 1'b1); chk("skz_z1", int'(inc_pc), 1);
    goto(0, 1, 1'b1);
    goto(4, 1, 1'b0); chk("skz_p4b", int'(inc_pc), 1);
    goto(6, 1, 1'b0); chk("skz_z0", int'(inc_pc), 0);
    goto(0, 1, 1'b0);

    // STO and JMP.
    goto(6, 6, 1'b0); chk("sto_p6_de", int'(data_e), 1); chk("sto_p6_wr", int'(wr), 0);
    goto(7, 6, 1'b0); chk("sto_p7_wr", int'(wr), 1); chk("sto_p7_de", int'(data_e), 1);
    goto(0, 6, 1'b0);
    goto(5, 7, 1'b0); chk("jmp_p5_rd", int'(rd), 0);
    goto(6, 7, 1'b0); chk("jmp_p6_ldpc", int'(ld_pc), 1); chk("jmp_p6_rd", int'(rd), 0);
    goto(7, 7, 1'b0); chk("jmp_p7_ldpc", int'(ld_pc), 1); chk("jmp_p7_rd", int'(rd), 0);
    goto(0, 7, 1'b0);
    chk("cnt_after_five", int'(instr_cnt), 5);

    // HLT and resume.
    goto(4, 0, 1'b0); chk("hlt_p4_halt", int'(halt), 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 1'b0, 1'b0);
      @(negedge clk);
      chk("halted_halt", int'(halt), 1);
      chk("halted_phase", int'(phase), 0);
      chk("halted_sel", int'(sel), 0);
    end
    step(0, 0, 1'b0, 1'b1);
    @(negedge clk);
    chk("resume_cycle_halt", int'(halt), 1);
    step(0, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("resumed_halt", int'(halt), 0);
    chk("resumed_phase", int'(phase), 0);
    chk("resumed_sel", int'(sel), 1);
    chk("hlt_not_counted", int'(instr_cnt), 5);

    // Reset in the middle of a STO.
    goto(6, 6, 1'b0);
    rst = 1'b1;
    step(6, 0, 1'b0, 1'b0);
    @(negedge clk);
    chk("midrst_phase", int'(phase), 0);
    chk("midrst_wr", int'(wr), 0);
    chk("midrst_cnt", int'(instr_cnt), 0);

    // Counter wrap with a 4-bit counter.
    for (int i = 0; i < 15; i++) begin
      goto(7, 2, 1'b0);
      goto(0, 2, 1'b0);
    end
    chk("cnt_15", int'(instr_cnt), 15);
    goto(7, 2, 1'b0);
    goto(0, 2, 1'b0);
    chk("cnt_wrap", int'(instr_cnt), 0);

    // Random traffic; the compare process checks every cycle.
    rop = 2;
    for (int i = 0; i < 3000; i++) begin
      if (mh || mp < 4) rop = $urandom_range(0, 7);
      step(rop, 1'($urandom), ($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0));
    end
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
